// File: rtl/mem_pkg.sv
// ============================================================================
// Module  : mem_pkg
// Brief   : Shared types and helpers for the data-memory responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Word-index width for a given storage depth (never below one bit).
    function automatic int idx_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// ============================================================================
// Module  : dmem_array
// Brief   : Synchronous single-port word RAM with registered, held read data.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IW    = idx_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic              clr,
    input  logic [IW-1:0]     idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[idx] <= wdata;
        end
    end

    // Read data only moves on a read, so it stays valid after the response.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= clr ? '0 : r_mem[idx];
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module  : dmem_responder
// Brief   : Multi-cycle data-memory responder with valid/ready request and a
//           one-cycle response pulse after a fixed latency.
//           Optional macro DMEM_ALIGN_CHECK_EN adds resp_err for misaligned
//           addresses.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              busy
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    output logic              resp_err
`endif
);

    localparam int IW = idx_width(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] c_cnt_init = CW'(LATENCY - 1);

    state_t              r_state;
    state_t              w_next;
    logic [CW-1:0]       r_cnt;
    logic                r_write;
    logic [IW-1:0]       r_idx;
    logic [WORD_W-1:0]   r_wdata;
    logic                w_accept;
    logic                w_access;
    logic                w_misalign;
    logic                w_we;
    logic                w_re;
    logic                w_unused_addr;

    assign w_accept = (r_state == IDLE) && req_valid;
    // Reset on the access edge wins: the pending store is dropped.
    assign w_access = (r_state == WAIT) && (r_cnt == '0) && !reset;
    assign w_unused_addr = ^{req_addr[31:IW+2], req_addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    logic [1:0] r_lsb;
    logic       r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lsb <= 2'b00;
            r_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_lsb <= req_addr[1:0];
            end
            if (w_access) begin
                r_err <= (r_lsb != 2'b00);
            end
        end
    end

    assign w_misalign = (r_lsb != 2'b00);
    assign resp_err   = r_err;
`else
    assign w_misalign = 1'b0;
`endif

    assign w_we = w_access && r_write && !w_misalign;
    assign w_re = w_access && !r_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_cnt   <= c_cnt_init;
            r_write <= req_write;
            r_idx   <= req_addr[IW+1:2];
            r_wdata <= req_wdata;
        end else if ((r_state == WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (r_cnt == '0) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                busy       = 1'b1;
                resp_valid = 1'b1;
                w_next     = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (w_we),
        .re    (w_re),
        .clr   (w_misalign),
        .idx   (r_idx),
        .wdata (r_wdata),
        .rdata (resp_rdata)
    );

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module  : tb_dmem_responder
// Brief   : Scoreboard bench for dmem_responder (honours DMEM_ALIGN_CHECK_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    localparam int DEPTH   = 64;
    localparam int LATENCY = 3;
    localparam int IW      = 6;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        busy;
`ifdef DMEM_ALIGN_CHECK_EN
    logic        resp_err;
`endif

    dmem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .busy       (busy)
`ifdef DMEM_ALIGN_CHECK_EN
        ,
        .resp_err   (resp_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          t0;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mdl [DEPTH];
    logic [31:0] mdl_rdata = '0;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_resp = -100;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Response side: pop the scoreboard on every pulse, police wait states.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (resp_valid) begin
                if (sbq.size() == 0) begin
                    check("spurious_resp", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("rdata", resp_rdata, e.rdata);
                    check("latency", 32'(cyc - e.t0), 32'(LATENCY));
                    check("resp_busy", 32'(busy), 32'd1);
                    check("resp_ready", 32'(req_ready), 32'd0);
`ifdef DMEM_ALIGN_CHECK_EN
                    check("resp_err", 32'(resp_err), 32'(e.err));
`endif
                    last_resp = cyc;
                end
            end else if (sbq.size() != 0 && cyc >= sbq[0].t0) begin
                check("wait_ready", 32'(req_ready), 32'd0);
                check("wait_busy", 32'(busy), 32'd1);
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input bit keep, input bit b2b);
        exp_t          e;
        int            n;
        logic [IW-1:0] ix;
        bit            mis;
        n   = 0;
        ix  = a[IW+1:2];
        mis = ALIGN && (a[1:0] != 2'b00);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        e.t0  = cyc + 1;
        e.err = mis;
        if (w) begin
            if (!mis) mdl[ix] = d;
        end else begin
            mdl_rdata = mis ? 32'd0 : mdl[ix];
        end
        e.rdata = mdl_rdata;
        if (b2b) check("b2b_accept", 32'(e.t0), 32'(last_resp + 2));
        sbq.push_back(e);
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            check("resp_timeout", 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        sbq.delete();
        mdl_rdata = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] old;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state and quiet idle
        repeat (5) begin
            @(negedge clk);
            check("idle_resp_valid", 32'(resp_valid), 32'd0);
        end
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);

        // Store then load
        send(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
        wait_done();
        send(1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
        wait_done();

        // Back-to-back pairs with req_valid held high
        for (int i = 0; i < 4; i++) begin
            send(1'b1, (i % 2 == 1) ? 32'h24 : 32'h20, 32'hC0DE0000 + 32'(i), 1'b1, i > 0);
            send(1'b0, (i % 2 == 1) ? 32'h24 : 32'h20, 32'hFFFFFFFF, 1'b1, 1'b1);
        end
        req_valid = 1'b0;
        wait_done();

        // Address aliasing modulo DEPTH*4
        send(1'b1, 32'h104, 32'h12345678, 1'b0, 1'b0);
        wait_done();
        send(1'b0, 32'h4, 32'h0, 1'b0, 1'b0);
        wait_done();

        // Reset during WAIT drops a pending store
        send(1'b1, 32'h30, 32'h11112222, 1'b0, 1'b0);
        wait_done();
        old = mdl[12];
        send(1'b1, 32'h30, 32'hAAAA5555, 1'b0, 1'b0);
        do_reset();
        mdl[12] = old;
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_rdata", resp_rdata, 32'd0);
        repeat (6) @(negedge clk);
        send(1'b0, 32'h30, 32'h0, 1'b0, 1'b0);
        wait_done();

        // Low address bits: checked when enabled, aliased otherwise
        send(1'b1, 32'h40, 32'h55550000, 1'b0, 1'b0);
        wait_done();
        send(1'b1, 32'h42, 32'hBAD0BAD0, 1'b0, 1'b0);
        wait_done();
        send(1'b0, 32'h42, 32'h0, 1'b0, 1'b0);
        wait_done();
        send(1'b0, 32'h40, 32'h0, 1'b0, 1'b0);
        wait_done();

        // Store leaves previous load data on resp_rdata
        send(1'b1, 32'h44, 32'h0BADF00D, 1'b0, 1'b0);
        wait_done();
        check("hold_rdata", resp_rdata, mdl_rdata);

        check("queue_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
